fazyrv_rf_chunker: RTL and testbench

//  Chunk sequencer between the core datapath and the dual-port register-file RAM.
//  - Fetches rs1/rs2 as full REGW words from the RAM.
//  - Streams them to the core CHUNKSIZE bits per cycle, LSB chunk first.
//  - Assembles the returned rd chunks into one word and writes it back in a single RAM write.
//  - RAM read ports are only used while RAM write enable is low, so read and write phases never overlap.

---
 rtl/fazyrv_rf_chunker_pkg.sv | 24 ++
 rtl/fazyrv_rf_chunker_if.sv | 41 ++++
 rtl/fazyrv_rf_chunker_shreg.sv | 31 +++
 rtl/fazyrv_rf_chunker.sv | 143 ++++++++++++++
 tb/tb_fazyrv_rf_chunker.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fazyrv_rf_chunker_pkg.sv
// Shared types and sizing helpers for the register-file chunk sequencer.
// Imported by the shift-register sub-module and the top.
package fazyrv_rf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        SHIFT,
        WRITE
    } state_t;

    function automatic int nchunks(input int regw, input int chunksize);
        return regw / chunksize;
    endfunction

    // A one-chunk word still needs a 1-bit counter.
    function automatic int cntw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNTW = cntw(nchunks(32, 2));

endpackage

// File: rtl/fazyrv_rf_chunker_if.sv
// Core-side and RAM-side signals of the chunk sequencer.
// The slave modport is the sequencer's view; master is the core/RAM side.
interface fazyrv_rf_chunker_if #(
    parameter int CHUNKSIZE = 2,
    parameter int REGW      = 32,
    parameter int ADRW      = 5
);
    logic                 start_i;
    logic [ADRW-1:0]      rs1_adr_i;
    logic [ADRW-1:0]      rs2_adr_i;
    logic [ADRW-1:0]      rd_adr_i;
    logic                 rd_we_i;
    logic [CHUNKSIZE-1:0] rd_chunk_i;
    logic [CHUNKSIZE-1:0] rs1_chunk_o;
    logic [CHUNKSIZE-1:0] rs2_chunk_o;
    logic                 chunk_vld_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 ram_we_o;
    logic [ADRW-1:0]      ram_waddr_o;
    logic [REGW-1:0]      ram_wdata_o;
    logic [ADRW-1:0]      ram_raddr_a_o;
    logic [ADRW-1:0]      ram_raddr_b_o;
    logic [REGW-1:0]      ram_rdata_a_i;
    logic [REGW-1:0]      ram_rdata_b_i;

    modport slave (
        input  start_i, rs1_adr_i, rs2_adr_i, rd_adr_i, rd_we_i, rd_chunk_i,
        input  ram_rdata_a_i, ram_rdata_b_i,
        output rs1_chunk_o, rs2_chunk_o, chunk_vld_o, busy_o, done_o,
        output ram_we_o, ram_waddr_o, ram_wdata_o, ram_raddr_a_o, ram_raddr_b_o
    );

    modport master (
        output start_i, rs1_adr_i, rs2_adr_i, rd_adr_i, rd_we_i, rd_chunk_i,
        output ram_rdata_a_i, ram_rdata_b_i,
        input  rs1_chunk_o, rs2_chunk_o, chunk_vld_o, busy_o, done_o,
        input  ram_we_o, ram_waddr_o, ram_wdata_o, ram_raddr_a_o, ram_raddr_b_o
    );

endinterface

// File: rtl/fazyrv_rf_chunker_shreg.sv
// Word shift register: parallel load, right shift with a chunk inserted at the MSB end.
// o_dat exposes the low OUTW bits: one chunk for rs streaming, the whole word for rd.
module fazyrv_chunk_shreg #(
    parameter int W         = 32,
    parameter int CHUNKSIZE = 2,
    parameter int OUTW      = CHUNKSIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_load,
    input  logic [W-1:0]         i_ld_dat,
    input  logic                 i_shift,
    input  logic [CHUNKSIZE-1:0] i_chunk,
    output logic [OUTW-1:0]      o_dat
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_ld_dat;
        end else if (i_shift) begin
            r_q <= {i_chunk, r_q[W-1:CHUNKSIZE]};
        end
    end

    assign o_dat = r_q[OUTW-1:0];

endmodule

// File: rtl/fazyrv_rf_chunker.sv
// Fetches rs1/rs2 words, streams them LSB chunk first, and writes the assembled rd back once.
// READ/LOAD/SHIFT xN/WRITE/IDLE; RAM write only in WRITE so reads and writes never share a cycle.
module fazyrv_rf_chunker
    import fazyrv_rf_pkg::*;
#(
    parameter int CHUNKSIZE = 2,
    parameter int REGW      = 32,
    parameter int ADRW      = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fazyrv_rf_chunker_if.slave  bus
);

    localparam int            N    = nchunks(REGW, CHUNKSIZE);
    localparam int            CW   = cntw(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [ADRW-1:0] r_rs1_adr;
    logic [ADRW-1:0] r_rs2_adr;
    logic [ADRW-1:0] r_rd_adr;
    logic            r_rd_we;
    logic            r_busy;
    logic            r_vld;
    logic            r_done;
    logic            r_we;

    logic                 w_load;
    logic                 w_shift;
    logic [REGW-1:0]      w_rs1_ld;
    logic [REGW-1:0]      w_rs2_ld;
    logic [CHUNKSIZE-1:0] w_rs1_chunk;
    logic [CHUNKSIZE-1:0] w_rs2_chunk;
    logic [REGW-1:0]      w_rd_word;

    assign w_load  = (r_state == LOAD);
    assign w_shift = (r_state == SHIFT);

    // x0 reads as zero whatever the RAM holds at that entry.
    assign w_rs1_ld = (r_rs1_adr == '0) ? '0 : bus.ram_rdata_a_i;
    assign w_rs2_ld = (r_rs2_adr == '0) ? '0 : bus.ram_rdata_b_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rs1_adr <= '0;
            r_rs2_adr <= '0;
            r_rd_adr  <= '0;
            r_rd_we   <= 1'b0;
            r_busy    <= 1'b0;
            r_vld     <= 1'b0;
            r_done    <= 1'b0;
            r_we      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_rs1_adr <= bus.rs1_adr_i;
                        r_rs2_adr <= bus.rs2_adr_i;
                        r_rd_adr  <= bus.rd_adr_i;
                        r_rd_we   <= bus.rd_we_i;
                        r_busy    <= 1'b1;
                        r_state   <= READ;
                    end
                end
                READ: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_cnt   <= '0;
                    r_vld   <= 1'b1;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_vld   <= 1'b0;
                        r_done  <= 1'b1;
                        r_we    <= r_rd_we && (r_rd_adr != '0);
                        r_state <= WRITE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    r_done  <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    fazyrv_chunk_shreg #(.W(REGW), .CHUNKSIZE(CHUNKSIZE), .OUTW(CHUNKSIZE)) u_rs1 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_load   (w_load),
        .i_ld_dat (w_rs1_ld),
        .i_shift  (w_shift),
        .i_chunk  ({CHUNKSIZE{1'b0}}),
        .o_dat    (w_rs1_chunk)
    );

    fazyrv_chunk_shreg #(.W(REGW), .CHUNKSIZE(CHUNKSIZE), .OUTW(CHUNKSIZE)) u_rs2 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_load   (w_load),
        .i_ld_dat (w_rs2_ld),
        .i_shift  (w_shift),
        .i_chunk  ({CHUNKSIZE{1'b0}}),
        .o_dat    (w_rs2_chunk)
    );

    // After N shifts the first rd chunk has travelled down to bit 0.
    fazyrv_chunk_shreg #(.W(REGW), .CHUNKSIZE(CHUNKSIZE), .OUTW(REGW)) u_rd (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_load   (1'b0),
        .i_ld_dat ({REGW{1'b0}}),
        .i_shift  (w_shift),
        .i_chunk  (bus.rd_chunk_i),
        .o_dat    (w_rd_word)
    );

    assign bus.rs1_chunk_o   = w_rs1_chunk;
    assign bus.rs2_chunk_o   = w_rs2_chunk;
    assign bus.chunk_vld_o   = r_vld;
    assign bus.busy_o        = r_busy;
    assign bus.done_o        = r_done;
    assign bus.ram_we_o      = r_we;
    assign bus.ram_waddr_o   = r_rd_adr;
    assign bus.ram_wdata_o   = w_rd_word;
    assign bus.ram_raddr_a_o = r_rs1_adr;
    assign bus.ram_raddr_b_o = r_rs2_adr;

endmodule

// File: tb/tb_fazyrv_rf_chunker.sv
// Bench for fazyrv_rf_chunker: transaction-level reference model plus directed and random traffic.
// Extra 1-bit and 2-bit chunk instances replay the basic fetch scenario.
module tb_fazyrv_rf_chunker;

    localparam int CS = 8;
    localparam int RW = 32;
    localparam int AW = 5;
    localparam int N  = RW / CS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fazyrv_rf_chunker_if #(.CHUNKSIZE(CS), .REGW(RW), .ADRW(AW)) bus ();
    fazyrv_rf_chunker #(.CHUNKSIZE(CS), .REGW(RW), .ADRW(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // RAM environment: two registered read ports, one write port, plus a bench poke path.
    logic          poke_en  = 1'b0;
    logic [AW-1:0] poke_adr = '0;
    logic [RW-1:0] poke_dat = '0;
    logic [RW-1:0] ram_mem [32];

    always @(posedge clk) begin
        if (poke_en) ram_mem[poke_adr] <= poke_dat;
        else if (bus.ram_we_o) ram_mem[bus.ram_waddr_o] <= bus.ram_wdata_o;
        bus.ram_rdata_a_i <= ram_mem[bus.ram_raddr_a_o];
        bus.ram_rdata_b_i <= ram_mem[bus.ram_raddr_b_o];
    end

    // Reference model: one transaction record, timed relative to the cycle start was seen.
    logic [RW-1:0] ref_mem [32];
    bit            act = 1'b0;
    int            t0  = 0;
    logic [RW-1:0] m_rs1, m_rs2, m_acc;
    logic [AW-1:0] m_ra, m_rb, m_rd;
    bit            m_we;

    always @(posedge clk) begin
        int kp;
        bit idle_prev;
        logic [RW-1:0] sh;
        cyc = cyc + 1;
        if (poke_en) ref_mem[poke_adr] = poke_dat;
        kp = cyc - 1 - t0;
        if (rst) begin
            act = 1'b0;
        end else begin
            if (act && kp >= 3 && kp <= 2 + N) begin
                sh = RW'(bus.rd_chunk_i) << (CS * (kp - 3));
                m_acc = m_acc | sh;
            end
            if (act && kp == 3 + N && m_we && m_rd != 0) ref_mem[m_rd] = m_acc;
            idle_prev = !act || kp >= 4 + N;
            if (idle_prev) begin
                act = 1'b0;
                if (bus.start_i) begin
                    act   = 1'b1;
                    t0    = cyc - 1;
                    m_ra  = bus.rs1_adr_i;
                    m_rb  = bus.rs2_adr_i;
                    m_rd  = bus.rd_adr_i;
                    m_we  = bus.rd_we_i;
                    m_rs1 = (m_ra == 0) ? '0 : ref_mem[m_ra];
                    m_rs2 = (m_rb == 0) ? '0 : ref_mem[m_rb];
                    m_acc = '0;
                end
            end
        end
    end

    logic [CS-1:0] cap1 [$];
    logic [CS-1:0] cap2 [$];
    int            done_q [$];
    int            we_cnt = 0;

    always @(negedge clk) begin
        int k;
        bit live, e_busy, e_vld, e_done, e_we;
        logic [RW-1:0] s1, s2;
        k      = cyc - t0;
        live   = !rst && act;
        e_busy = live && k >= 1 && k <= 3 + N;
        e_vld  = live && k >= 3 && k <= 2 + N;
        e_done = live && k == 3 + N;
        e_we   = e_done && m_we && (m_rd != 0);
        chk("busy", bus.busy_o, e_busy);
        chk("chunk_vld", bus.chunk_vld_o, e_vld);
        chk("done", bus.done_o, e_done);
        chk("ram_we", bus.ram_we_o, e_we);
        if (e_vld) begin
            s1 = m_rs1 >> (CS * (k - 3));
            s2 = m_rs2 >> (CS * (k - 3));
            chk("rs1_chunk", bus.rs1_chunk_o, s1[CS-1:0]);
            chk("rs2_chunk", bus.rs2_chunk_o, s2[CS-1:0]);
        end
        if (live && k == 1) begin
            chk("raddr_a", bus.ram_raddr_a_o, m_ra);
            chk("raddr_b", bus.ram_raddr_b_o, m_rb);
        end
        if (e_we) begin
            chk("waddr", bus.ram_waddr_o, m_rd);
            chk("wdata", bus.ram_wdata_o, m_acc);
        end
        if (rst) begin
            chk("rst_rs1_chunk", bus.rs1_chunk_o, 0);
            chk("rst_wdata", bus.ram_wdata_o, 0);
        end
        if (bus.chunk_vld_o) begin
            cap1.push_back(bus.rs1_chunk_o);
            cap2.push_back(bus.rs2_chunk_o);
        end
        if (bus.done_o) done_q.push_back(cyc);
        if (bus.ram_we_o) we_cnt++;
    end

    function automatic logic [RW-1:0] packq(input logic [CS-1:0] q[$]);
        logic [RW-1:0] w = '0;
        foreach (q[i]) w = w | (RW'(q[i]) << (CS * i));
        return w;
    endfunction

    task automatic poke(input int a, input logic [RW-1:0] d);
        poke_en  = 1'b1;
        poke_adr = AW'(a);
        poke_dat = d;
        @(posedge clk); #2;
        poke_en  = 1'b0;
    endtask

    // Issues one transaction from IDLE; addresses and rd_we are scrambled once start is taken.
    task automatic txn(input int r1, input int r2, input int rd, input bit we,
                       input logic [RW-1:0] rdw, output int t);
        bus.rs1_adr_i = AW'(r1);
        bus.rs2_adr_i = AW'(r2);
        bus.rd_adr_i  = AW'(rd);
        bus.rd_we_i   = we;
        bus.start_i   = 1'b1;
        t = cyc;
        @(posedge clk); #2;
        bus.start_i   = 1'b0;
        bus.rs1_adr_i = AW'($urandom);
        bus.rs2_adr_i = AW'($urandom);
        bus.rd_adr_i  = AW'($urandom);
        bus.rd_we_i   = ~we;
        for (int c = t + 1; c <= t + 4 + N; c++) begin
            if (c >= t + 3 && c <= t + 2 + N) bus.rd_chunk_i = rdw[CS*(c-t-3) +: CS];
            else bus.rd_chunk_i = CS'($urandom);
            @(posedge clk); #2;
        end
    endtask

    // Narrow-chunk builds replaying the basic rs1=3 / rs2=5 fetch.
    function automatic logic [RW-1:0] rom(input logic [AW-1:0] a);
        return (a == 3) ? 32'h11223344 : (a == 5) ? 32'hA0B0C0D0 : 32'h0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cs
        localparam int CSX = (g == 0) ? 1 : 2;
        localparam int NX  = RW / CSX;
        bit fin = 1'b0;

        fazyrv_rf_chunker_if #(.CHUNKSIZE(CSX), .REGW(RW), .ADRW(AW)) gbus ();
        fazyrv_rf_chunker #(.CHUNKSIZE(CSX), .REGW(RW), .ADRW(AW)) gdut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (gbus)
        );

        always @(posedge clk) begin
            gbus.ram_rdata_a_i <= rom(gbus.ram_raddr_a_o);
            gbus.ram_rdata_b_i <= rom(gbus.ram_raddr_b_o);
        end

        initial begin
            int t, cnt, first_c, done_c;
            logic [RW-1:0] got1, got2;
            gbus.start_i    = 1'b0;
            gbus.rs1_adr_i  = '0;
            gbus.rs2_adr_i  = '0;
            gbus.rd_adr_i   = '0;
            gbus.rd_we_i    = 1'b0;
            gbus.rd_chunk_i = '0;
            @(negedge rst);
            @(posedge clk); #2;
            gbus.rs1_adr_i = AW'(3);
            gbus.rs2_adr_i = AW'(5);
            gbus.start_i   = 1'b1;
            t = cyc; cnt = 0; first_c = -1; done_c = -1; got1 = '0; got2 = '0;
            for (int c = t; c <= t + NX + 5; c++) begin
                @(negedge clk);
                if (gbus.chunk_vld_o) begin
                    if (first_c < 0) first_c = c;
                    got1 = got1 | (RW'(gbus.rs1_chunk_o) << (CSX * cnt));
                    got2 = got2 | (RW'(gbus.rs2_chunk_o) << (CSX * cnt));
                    cnt++;
                end
                if (gbus.done_o) done_c = c;
                @(posedge clk); #2;
                gbus.start_i = 1'b0;
            end
            chk($sformatf("cs%0d_chunk_count", CSX), cnt, NX);
            chk($sformatf("cs%0d_rs1_word", CSX), got1, 32'h11223344);
            chk($sformatf("cs%0d_rs2_word", CSX), got2, 32'hA0B0C0D0);
            chk($sformatf("cs%0d_first_chunk_cycle", CSX), first_c - t, 3);
            chk($sformatf("cs%0d_done_cycle", CSX), done_c - t, (CSX == 1) ? 35 : 19);
            fin = 1'b1;
        end
    end

    initial begin
        int t, we0, s, nd;
        bus.start_i    = 1'b0;
        bus.rs1_adr_i  = '0;
        bus.rs2_adr_i  = '0;
        bus.rd_adr_i   = '0;
        bus.rd_we_i    = 1'b0;
        bus.rd_chunk_i = '0;
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 32; i++) poke(i, 32'h9E3779B9 * (i + 1));

        chk("reset_busy", bus.busy_o, 0);
        chk("reset_vld", bus.chunk_vld_o, 0);
        chk("reset_done", bus.done_o, 0);
        chk("reset_we", bus.ram_we_o, 0);
        chk("reset_waddr", bus.ram_waddr_o, 0);
        chk("reset_wdata", bus.ram_wdata_o, 0);
        chk("reset_raddr_a", bus.ram_raddr_a_o, 0);
        chk("reset_raddr_b", bus.ram_raddr_b_o, 0);
        chk("reset_rs1_chunk", bus.rs1_chunk_o, 0);
        chk("reset_rs2_chunk", bus.rs2_chunk_o, 0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Plain fetch of two registers.
        poke(3, 32'h11223344);
        poke(5, 32'hA0B0C0D0);
        cap1.delete(); cap2.delete(); done_q.delete();
        txn(3, 5, 9, 1'b0, $urandom, t);
        chk("s1_rs1_word", packq(cap1), 32'h11223344);
        chk("s1_rs2_word", packq(cap2), 32'hA0B0C0D0);
        chk("s1_chunk_count", cap1.size(), 4);
        chk("s1_done_cycle", done_q.size() == 1 ? done_q[0] - t : -1, 7);

        // Write-back then read-after-write.
        we0 = we_cnt;
        txn(1, 2, 7, 1'b1, 32'hDEADBEEF, t);
        chk("s2_we_pulses", we_cnt - we0, 1);
        chk("s2_ram7", ram_mem[7], 32'hDEADBEEF);
        cap1.delete(); cap2.delete();
        txn(7, 7, 4, 1'b0, $urandom, t);
        chk("s2_reread_rs1", packq(cap1), 32'hDEADBEEF);
        chk("s2_reread_rs2", packq(cap2), 32'hDEADBEEF);

        // x0 is never written and always reads zero.
        poke(0, 32'hFFFFFFFF);
        we0 = we_cnt;
        txn(5, 3, 0, 1'b1, $urandom, t);
        chk("s3_x0_no_write", we_cnt - we0, 0);
        cap1.delete(); cap2.delete();
        txn(0, 0, 6, 1'b0, $urandom, t);
        chk("s3_x0_rs1", packq(cap1), 0);
        chk("s3_x0_rs2", packq(cap2), 0);
        chk("s3_x0_count", cap1.size(), 4);

        // start held high: one transaction every 2+N+2 cycles.
        done_q.delete();
        s = cyc;
        bus.start_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.rs1_adr_i  = AW'($urandom);
            bus.rs2_adr_i  = AW'($urandom);
            bus.rd_adr_i   = AW'($urandom);
            bus.rd_we_i    = 1'($urandom);
            bus.rd_chunk_i = CS'($urandom);
            @(posedge clk); #2;
        end
        bus.start_i = 1'b0;
        repeat (10) begin
            bus.rd_chunk_i = CS'($urandom);
            @(posedge clk); #2;
        end
        nd = 0;
        foreach (done_q[i]) if (done_q[i] >= s && done_q[i] < s + 40) nd++;
        chk("s4_done_count", nd, 5);

        // Reset during SHIFT aborts without writing.
        poke(12, 32'h0BADF00D);
        we0 = we_cnt;
        bus.rs1_adr_i = AW'(4);
        bus.rs2_adr_i = AW'(6);
        bus.rd_adr_i  = AW'(12);
        bus.rd_we_i   = 1'b1;
        bus.start_i   = 1'b1;
        t = cyc;
        @(posedge clk); #2;
        bus.start_i = 1'b0;
        repeat (3) begin
            bus.rd_chunk_i = CS'($urandom);
            @(posedge clk); #2;
        end
        chk("s5_in_shift", bus.chunk_vld_o, 1);
        rst = 1'b1;
        #1;
        chk("s5_abort_busy", bus.busy_o, 0);
        chk("s5_abort_vld", bus.chunk_vld_o, 0);
        chk("s5_abort_we", bus.ram_we_o, 0);
        chk("s5_abort_rs1", bus.rs1_chunk_o, 0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk); #2;
        end
        chk("s5_no_write", we_cnt - we0, 0);
        chk("s5_ram12_kept", ram_mem[12], 32'h0BADF00D);
        cap1.delete(); cap2.delete(); done_q.delete();
        txn(12, 12, 13, 1'b1, 32'h13579BDF, t);
        chk("s5_fresh_rs1", packq(cap1), 32'h0BADF00D);
        chk("s5_fresh_done", done_q.size() == 1 ? done_q[0] - t : -1, 7);
        chk("s5_fresh_write", ram_mem[13], 32'h13579BDF);

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #2;
            end
            txn($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom), $urandom, t);
        end

        for (int i = 0; i < 2000 && !(g_cs[0].fin && g_cs[1].fin); i++) @(posedge clk);
        chk("narrow_builds_finished", {g_cs[1].fin, g_cs[0].fin}, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
